// File: rtl/dual_port_ram.sv
// Simple-dual-port RAM with byte-lane write masking, registered read port and a sweep clear engine.
// Optional macro RAM_FWD_EN: same-address same-edge read returns the merged (write-first) word.
module dual_port_ram #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    BYTE_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    output logic                             busy,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_mask,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid
);

    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]            state_r;
    logic [ADDR_WIDTH:0]   cnt_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;

    logic                  idle_s;
    logic                  sweep_last_s;
    logic [DATA_WIDTH-1:0] wr_merged_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // Lanes with a set mask bit take the new data, the others keep the old word.
    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                res[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return res;
    endfunction

    assign idle_s       = (state_r == ST_IDLE);
    assign sweep_last_s = (cnt_r[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});

    // Merged write word and read-port source word.
    always_comb begin
        wr_merged_s = lane_merge(mem_r[wr_addr], wr_data, wr_mask);
`ifdef RAM_FWD_EN
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_word_s = wr_merged_s;
        end else begin
            rd_word_s = mem_r[rd_addr];
        end
`else
        rd_word_s = mem_r[rd_addr];
`endif
    end

    // Sweep FSM: counter walks every address once, then the ports open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    cnt_r <= cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    if (sweep_last_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                ST_IDLE: begin
                    if (clear) begin
                        state_r <= ST_CLEAR;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Storage array: sweep writes take priority, port writes only in idle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_r == ST_CLEAR) begin
                mem_r[cnt_r[ADDR_WIDTH-1:0]] <= CLEAR_VALUE;
            end else if (wr_en) begin
                mem_r[wr_addr] <= wr_merged_s;
            end
        end
    end

    // Registered read port; data holds when no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else if (idle_s && rd_en) begin
            rd_data_r  <= rd_word_s;
            rd_valid_r <= 1'b1;
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    assign busy     = (state_r == ST_CLEAR);
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;

endmodule
